// File: rtl/posit_lane_scheduler.sv
// Round-robin lane packer for a shared multi-precision posit datapath (1x full, 2x half, 4x quart).
// Tracks lane ownership through the fixed-latency pipe and routes each result lane back to its requester.
module posit_lane_scheduler #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned FULL_L     = 32,
  parameter int unsigned DP_LATENCY = 3,
  parameter int unsigned PACK_WAIT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [2*N_REQ-1:0]        req_prec,
  input  logic [FULL_L*N_REQ-1:0]   req_a,
  input  logic [FULL_L*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      dp_valid,
  output logic [1:0]                dp_mode,
  output logic [FULL_L-1:0]         dp_a,
  output logic [FULL_L-1:0]         dp_b,
  input  logic                      dp_res_valid,
  input  logic [FULL_L-1:0]         dp_res,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [FULL_L*N_REQ-1:0]   rsp_data,
  output logic                      err_sync
);

  localparam int unsigned HALF_L  = FULL_L / 2;
  localparam int unsigned QUART_L = FULL_L / 4;
  localparam int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WC_W    = (PACK_WAIT > 0) ? $clog2(PACK_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    MODE_FULL  = 2'd0,
    MODE_HALF  = 2'd1,
    MODE_QUART = 2'd2
  } mode_e;

  typedef struct packed {
    logic                 valid;
    logic [1:0]           mode;
    logic [3:0]           own_v;
    logic [3:0][ID_W-1:0] own_id;
  } tag_t;

  function automatic mode_e norm_prec(input logic [1:0] p);
    case (p)
      2'd1:    return MODE_HALF;
      2'd2:    return MODE_QUART;
      default: return MODE_FULL;
    endcase
  endfunction

  function automatic logic [2:0] lane_cnt(input mode_e m);
    case (m)
      MODE_HALF:  return 3'd2;
      MODE_QUART: return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

  logic [ID_W-1:0]      rr_ptr;
  logic [WC_W-1:0]      wait_cnt;
  logic [3:0]           iss_own_v;
  logic [3:0][ID_W-1:0] iss_own_id;
  tag_t                 pipe [DP_LATENCY];
  tag_t                 head;

  logic [3:0]           lane_v;
  logic [3:0][ID_W-1:0] lane_id;
  mode_e                sel_mode;
  logic [ID_W-1:0]      win;
  logic                 win_found;
  logic [2:0]           cand_cnt;
  logic [N_REQ-1:0]     grant_mask;
  logic [FULL_L-1:0]    pack_a;
  logic [FULL_L-1:0]    pack_b;
  logic                 any_valid;
  logic                 issue;
  logic [FULL_L-1:0]    res_lane [4];

  // One scan from rr_ptr: the first valid requester fixes the mode, later matches fill lanes in RR order.
  always_comb begin : select
    int unsigned idx;
    mode_e       p;
    idx        = 0;
    p          = MODE_FULL;
    win        = '0;
    win_found  = 1'b0;
    sel_mode   = MODE_FULL;
    cand_cnt   = '0;
    lane_v     = '0;
    lane_id    = '0;
    grant_mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % N_REQ;
      if (req_valid[idx]) begin
        p = norm_prec(req_prec[2*idx +: 2]);
        if (!win_found) begin
          win_found = 1'b1;
          win       = ID_W'(idx);
          sel_mode  = p;
        end
        if (p == sel_mode && cand_cnt < lane_cnt(sel_mode)) begin
          lane_v[cand_cnt[1:0]]  = 1'b1;
          lane_id[cand_cnt[1:0]] = ID_W'(idx);
          grant_mask[idx]        = 1'b1;
          cand_cnt               = cand_cnt + 3'd1;
        end
      end
    end
    any_valid = |req_valid;
    issue     = rst_n && any_valid &&
                (sel_mode == MODE_FULL || cand_cnt == lane_cnt(sel_mode) ||
                 wait_cnt == WC_W'(PACK_WAIT));
    req_ready = issue ? grant_mask : '0;
  end

  always_comb begin : pack
    pack_a = '0;
    pack_b = '0;
    case (sel_mode)
      MODE_HALF: begin
        for (int unsigned k = 0; k < 2; k++) begin
          if (lane_v[k]) begin
            pack_a[HALF_L*k +: HALF_L] = req_a[FULL_L*32'(lane_id[k]) +: HALF_L];
            pack_b[HALF_L*k +: HALF_L] = req_b[FULL_L*32'(lane_id[k]) +: HALF_L];
          end
        end
      end
      MODE_QUART: begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (lane_v[k]) begin
            pack_a[QUART_L*k +: QUART_L] = req_a[FULL_L*32'(lane_id[k]) +: QUART_L];
            pack_b[QUART_L*k +: QUART_L] = req_b[FULL_L*32'(lane_id[k]) +: QUART_L];
          end
        end
      end
      default: begin
        if (lane_v[0]) begin
          pack_a = req_a[FULL_L*32'(lane_id[0]) +: FULL_L];
          pack_b = req_b[FULL_L*32'(lane_id[0]) +: FULL_L];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      wait_cnt   <= '0;
      dp_valid   <= 1'b0;
      dp_mode    <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
      iss_own_v  <= '0;
      iss_own_id <= '0;
    end else begin
      dp_valid   <= issue;
      dp_mode    <= issue ? sel_mode : MODE_FULL;
      dp_a       <= issue ? pack_a : '0;
      dp_b       <= issue ? pack_b : '0;
      iss_own_v  <= issue ? lane_v : '0;
      iss_own_id <= issue ? lane_id : '0;
      if (issue) begin
        wait_cnt <= '0;
        rr_ptr   <= (32'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
      end else if (any_valid) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Stage 0 captures the issue visible on the dp_* outputs, so the head lines up with dp_res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DP_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: dp_valid, mode: dp_mode, own_v: iss_own_v, own_id: iss_own_id};
      for (int unsigned i = 1; i < DP_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign head = pipe[DP_LATENCY-1];

  always_comb begin : unpack
    for (int unsigned k = 0; k < 4; k++) res_lane[k] = '0;
    case (head.mode)
      MODE_HALF: begin
        for (int unsigned k = 0; k < 2; k++) res_lane[k][HALF_L-1:0] = dp_res[HALF_L*k +: HALF_L];
      end
      MODE_QUART: begin
        for (int unsigned k = 0; k < 4; k++) res_lane[k][QUART_L-1:0] = dp_res[QUART_L*k +: QUART_L];
      end
      default: res_lane[0] = dp_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err_sync  <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (head.valid && dp_res_valid) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (head.own_v[k]) begin
            rsp_valid[head.own_id[k]]                     <= 1'b1;
            rsp_data[FULL_L*32'(head.own_id[k]) +: FULL_L] <= res_lane[k];
          end
        end
      end
      if (head.valid ^ dp_res_valid) err_sync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_posit_lane_scheduler.sv
// Directed bench for posit_lane_scheduler with a fixed-latency datapath model returning preset results.
module tb_posit_lane_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [2*N-1:0]   req_prec = '0;
  logic [W*N-1:0]   req_a = '0;
  logic [W*N-1:0]   req_b = '0;
  logic [N-1:0]     req_ready;
  logic             dp_valid;
  logic [1:0]       dp_mode;
  logic [W-1:0]     dp_a;
  logic [W-1:0]     dp_b;
  logic             dp_res_valid;
  logic [W-1:0]     dp_res;
  logic [N-1:0]     rsp_valid;
  logic [W*N-1:0]   rsp_data;
  logic             err_sync;

  int checks   = 0;
  int failures = 0;

  posit_lane_scheduler #(
    .N_REQ      (N),
    .FULL_L     (W),
    .DP_LATENCY (3),
    .PACK_WAIT  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_prec     (req_prec),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .dp_valid     (dp_valid),
    .dp_mode      (dp_mode),
    .dp_a         (dp_a),
    .dp_b         (dp_b),
    .dp_res_valid (dp_res_valid),
    .dp_res       (dp_res),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .err_sync     (err_sync)
  );

  always #5 clk = ~clk;

  // Datapath model: 3-cycle delay line, not affected by rst_n, result preset per test.
  logic [2:0]   mv = '0;
  logic [W-1:0] md0 = '0, md1 = '0, md2 = '0;
  logic [W-1:0] next_res = '0;
  logic         inject = 1'b0;

  always @(posedge clk) begin
    mv  <= {mv[1:0], dp_valid};
    md0 <= next_res;
    md1 <= md0;
    md2 <= md1;
  end

  assign dp_res_valid = mv[2] | inject;
  assign dp_res       = md2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    req_valid = '0;
    req_prec  = '0;
    req_a     = '0;
    req_b     = '0;
    inject    = 1'b0;
    rst_n     = 1'b0;
    repeat (4) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic set_req(input int unsigned r, input logic [1:0] p,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[r]       = 1'b1;
    req_prec[2*r +: 2] = p;
    req_a[W*r +: W]    = a;
    req_b[W*r +: W]    = b;
  endtask

  task automatic test_reset;
    req_valid = '0;
    rst_n     = 1'b0;
    tick;
    tick;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (dp_valid !== 1'b0) begin failures++; $display("FAIL reset_dp_valid got=%b exp=0", dp_valid); end
    checks++; if (dp_a !== 32'h0 || dp_b !== 32'h0 || dp_mode !== 2'd0) begin failures++; $display("FAIL reset_dp_bus got a=%h b=%h m=%0d exp 0", dp_a, dp_b, dp_mode); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_data !== '0) begin failures++; $display("FAIL reset_rsp got v=%b d=%h exp 0", rsp_valid, rsp_data); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL reset_err_sync got=%b exp=0", err_sync); end
    req_valid = '0;
  endtask

  task automatic test_single_full;
    apply_reset;
    next_res = 32'h48000000;
    set_req(0, 2'd0, 32'h40000000, 32'h40000000);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL full_grant got=%b exp=0001", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (dp_valid !== 1'b1 || dp_mode !== 2'd0) begin failures++; $display("FAIL full_issue got v=%b m=%0d exp v=1 m=0", dp_valid, dp_mode); end
    checks++; if (dp_a !== 32'h40000000 || dp_b !== 32'h40000000) begin failures++; $display("FAIL full_operands got a=%h b=%h exp 40000000", dp_a, dp_b); end
    repeat (3) tick;
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL full_rsp_early got=%b exp=0000", rsp_valid); end
    tick;
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL full_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_data[31:0] !== 32'h48000000) begin failures++; $display("FAIL full_rsp_data got=%h exp=48000000", rsp_data[31:0]); end
    tick;
    checks++; if (rsp_valid !== 4'b0000 || err_sync !== 1'b0) begin failures++; $display("FAIL full_rsp_pulse got v=%b err=%b exp 0/0", rsp_valid, err_sync); end
  endtask

  task automatic test_quart_pack;
    logic [W-1:0] er;
    logic [7:0]   bval;
    apply_reset;
    er       = 32'hD4C3B2A1;
    next_res = er;
    for (int unsigned k = 0; k < 4; k++) begin
      bval = 8'h11 * 8'(k + 1);
      set_req(k, 2'd2, {24'hABCDEF, bval}, {24'h777777, 8'(k + 1)});
    end
    #1;
    checks++; if (req_ready !== 4'b1111) begin failures++; $display("FAIL quart_grant got=%b exp=1111", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (dp_valid !== 1'b1 || dp_mode !== 2'd2) begin failures++; $display("FAIL quart_issue got v=%b m=%0d exp v=1 m=2", dp_valid, dp_mode); end
    checks++; if (dp_a !== 32'h44332211) begin failures++; $display("FAIL quart_dp_a got=%h exp=44332211", dp_a); end
    checks++; if (dp_b !== 32'h04030201) begin failures++; $display("FAIL quart_dp_b got=%h exp=04030201", dp_b); end
    repeat (4) tick;
    checks++; if (rsp_valid !== 4'b1111) begin failures++; $display("FAIL quart_rsp_valid got=%b exp=1111", rsp_valid); end
    for (int unsigned k = 0; k < 4; k++) begin
      checks++;
      if (rsp_data[W*k +: W] !== {24'h0, er[8*k +: 8]}) begin
        failures++; $display("FAIL quart_rsp_data%0d got=%h exp=%h", k, rsp_data[W*k +: W], {24'h0, er[8*k +: 8]});
      end
    end
  endtask

  task automatic test_pack_timeout;
    apply_reset;
    next_res = 32'h55557777;
    set_req(1, 2'd1, 32'hFFFFABCD, 32'h99991234);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL timeout_hold_ready%0d got=%b exp=0000", i, req_ready); end
      tick;
      checks++; if (dp_valid !== 1'b0) begin failures++; $display("FAIL timeout_hold_issue%0d got=%b exp=0", i, dp_valid); end
    end
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL timeout_grant got=%b exp=0010", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (dp_valid !== 1'b1 || dp_mode !== 2'd1) begin failures++; $display("FAIL timeout_issue got v=%b m=%0d exp v=1 m=1", dp_valid, dp_mode); end
    checks++; if (dp_a !== 32'h0000ABCD || dp_b !== 32'h00001234) begin failures++; $display("FAIL timeout_operands got a=%h b=%h exp 0000abcd/00001234", dp_a, dp_b); end
    checks++; if (dut.rr_ptr !== 2'd2) begin failures++; $display("FAIL timeout_rr_ptr got=%0d exp=2", dut.rr_ptr); end
    repeat (4) tick;
    checks++; if (rsp_valid !== 4'b0010 || rsp_data[63:32] !== 32'h00007777) begin failures++; $display("FAIL timeout_rsp got v=%b d=%h exp 0010/00007777", rsp_valid, rsp_data[63:32]); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy [8];
    int n0;
    int n1;
    apply_reset;
    exp_rdy  = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
    n0       = 0;
    n1       = 0;
    next_res = 32'h12345678;
    set_req(0, 2'd0, 32'h1, 32'h1);
    set_req(1, 2'd1, 32'h2, 32'h2);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (req_ready !== exp_rdy[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_rdy[i]); end
      tick;
      checks++; if (dp_valid !== (exp_rdy[i] != 4'd0)) begin failures++; $display("FAIL rr_issue%0d got=%b exp=%b", i, dp_valid, exp_rdy[i] != 4'd0); end
      if (exp_rdy[i] != 4'd0) begin
        checks++;
        if (dp_mode !== (exp_rdy[i] == 4'b0001 ? 2'd0 : 2'd1)) begin
          failures++; $display("FAIL rr_mode%0d got=%0d exp=%0d", i, dp_mode, exp_rdy[i] == 4'b0001 ? 0 : 1);
        end
      end
      n0 += int'(rsp_valid[0]);
      n1 += int'(rsp_valid[1]);
    end
    req_valid = '0;
    repeat (6) begin
      tick;
      n0 += int'(rsp_valid[0]);
      n1 += int'(rsp_valid[1]);
    end
    checks++; if (n0 != 2 || n1 != 2) begin failures++; $display("FAIL rr_rsp_count got r0=%0d r1=%0d exp 2/2", n0, n1); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL rr_err_sync got=%b exp=0", err_sync); end
  endtask

  task automatic test_sync_error;
    apply_reset;
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL syncerr_pre got=%b exp=0", err_sync); end
    inject = 1'b1;
    tick;
    inject = 1'b0;
    checks++; if (err_sync !== 1'b1 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL syncerr_set got err=%b v=%b exp 1/0000", err_sync, rsp_valid); end
    repeat (3) tick;
    checks++; if (err_sync !== 1'b1 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL syncerr_sticky got err=%b v=%b exp 1/0000", err_sync, rsp_valid); end
  endtask

  task automatic test_reset_midflight;
    apply_reset;
    next_res = 32'hCAFEF00D;
    set_req(0, 2'd0, 32'h40000000, 32'h3C000000);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_grant got=%b exp=0001", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (dp_valid !== 1'b1) begin failures++; $display("FAIL midrst_issue got=%b exp=1", dp_valid); end
    tick;
    rst_n = 1'b0;
    #1;
    checks++; if (dp_valid !== 1'b0 || dp_a !== 32'h0 || rsp_valid !== 4'b0000 || err_sync !== 1'b0) begin failures++; $display("FAIL midrst_clear got v=%b a=%h rv=%b err=%b exp all 0", dp_valid, dp_a, rsp_valid, err_sync); end
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    checks++; if (err_sync !== 1'b1) begin failures++; $display("FAIL midrst_err_sync got=%b exp=1", err_sync); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL midrst_no_rsp got=%b exp=0000", rsp_valid); end
  endtask

  initial begin
    test_reset;
    test_single_full;
    test_quart_pack;
    test_pack_timeout;
    test_round_robin;
    test_sync_error;
    test_reset_midflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_lane_scheduler.md
Name: posit_lane_scheduler

Overview:
- Shares one multi-precision posit datapath (modes: one 32-bit lane, two 16-bit lanes or four 8-bit lanes) between N_REQ requesters.
- Each cycle it picks a precision by round-robin and packs same-precision requests into free lanes.
- It waits a bounded time to fill lanes, then issues.
- It tracks in-flight lane ownership through the fixed-latency pipe and steers each result lane back to its requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FULL_L, 32, datapath word width. Half lane = FULL_L/2, quart lane = FULL_L/4.
- DP_LATENCY, 3, cycles from dp_valid to matching dp_res_valid (>=1).
- PACK_WAIT, 2, max cycles to hold a partially-filled half/quart issue. 0 = never wait.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  request pending per requester.
- req_prec  in  2*N_REQ  per requester: 0=full, 1=half, 2=quart, 3=treated as full.
- req_a  in  FULL_L*N_REQ  operand A per requester; the narrower precisions use the low bits.
- req_b  in  FULL_L*N_REQ  operand B per requester, same layout.
- req_ready  out  N_REQ  grant pulse; the request is consumed this cycle.
- dp_valid  out  1  issue to datapath.
- dp_mode  out  2  0=full, 1=half, 2=quart.
- dp_a  out  FULL_L  packed operand A.
- dp_b  out  FULL_L  packed operand B.
- dp_res_valid  in  1  datapath result valid.
- dp_res  in  FULL_L  packed result.
- rsp_valid  out  N_REQ  result pulse per requester. There is no backpressure.
- rsp_data  out  FULL_L*N_REQ  result, lane zero-extended to FULL_L.
- err_sync  out  1  sticky: dp_res_valid mismatch with the tracked pipe.

Behaviour:
- Reset (async assert, sync deassert), all values 0:
  - outputs, RR pointer, wait counter, tracking pipe, err_sync.
  - Reset mid-operation discards in-flight tags; later dp_res_valid pulses set err_sync.
- Requester rule: req_valid, req_prec and operands are held stable until req_ready. The scheduler never grants a requester whose req_valid is 0.
- Selection, combinational on registered state:
  - Winner W = first valid requester at or after rr_ptr (wrapping).
  - Mode M = prec(W). Lane count L = 1/2/4 for full/half/quart.
  - Candidates = valid requesters with prec==M, scanned in RR order from W, truncated to L.
  - Lane k goes to the k-th candidate: half lane k = bits[16k+15:16k]; quart lane k = bits[8k+7:8k].
  - Unused lanes drive 0.
- Issue decision, each cycle with any req_valid:
  - M==full: issue.
  - Otherwise issue if the candidate count equals L or wait_cnt==PACK_WAIT.
  - Otherwise hold: dp_valid=0, wait_cnt++.
- Issue: dp_valid, dp_mode, dp_a and dp_b are registered, driven 1 cycle after the decision. req_ready pulses combinationally in the decision cycle for all candidates.
- On issue: wait_cnt<=0, rr_ptr<=(W+1) mod N_REQ. With no req_valid, wait_cnt<=0 and rr_ptr is unchanged.
- The winner may change during a hold only if a new requester at a higher RR position appears. wait_cnt is not reset on such a change.
- Tracking pipe: DP_LATENCY stages, one entry per cycle with fields {valid, mode, owner_valid[4], owner_id[4]}. The entry is written at the dp_valid edge and shifted every cycle.
- Response: when the pipe head is valid and dp_res_valid=1:
  - For each owned lane, pulse rsp_valid[owner] for one cycle (registered, 1 cycle after dp_res_valid).
  - rsp_data[owner] = lane bits zero-extended.
- Error: head valid XOR dp_res_valid sets err_sync. err_sync is cleared only by reset. Results without a tag are dropped.
- Throughput: one issue per cycle maximum. Back-to-back issues are allowed.
- A requester holds at most one lane per issue and at most one outstanding request. It must not re-assert req_valid until its rsp_valid. The scheduler does not check this.

Test Plan:
- Single full request: req0 prec=0, a=0x40000000, b=0x40000000. Expect req_ready0 in cycle T, dp_valid=1 mode=0 at T+1. Model returns dp_res=0x48000000 at T+1+3. Expect rsp_valid0 with rsp_data0=0x48000000 one cycle later.
- Quart packing: req0..3 all prec=2, a low bytes 0x11/0x22/0x33/0x44. Expect a same-cycle grant of all four and dp_a=0x44332211. Each rsp_data gets its byte zero-extended.
- Pack timeout: only req1 prec=1, PACK_WAIT=2. Expect 2 hold cycles, then issue with lane1=0 and rr_ptr=2.
- Round-robin fairness: req0 prec=0 and req1 prec=1 held continuously. Expect the issue sequence to alternate full (req0) and half (req1, after timeout). Neither requester starves.
- Sync error: inject dp_res_valid with the pipe empty. Expect err_sync=1 sticky and no rsp_valid.
- Reset mid-flight: assert rst_n=0 one cycle after issue. Expect all outputs 0 immediately. Returning dp_res_valid after release sets err_sync.
